// File: rtl/bus_arbiter_rr_if.sv
// Request/grant bundle between the bus requesters and the round-robin arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface bus_arbiter_rr_if #(
    parameter int CNT_W = 4
);
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic             s1;
    logic             s0;
    logic             bus_valid;
    logic [CNT_W-1:0] owner_cnt;

    modport master (
        output req,
        input  gnt,
        input  s1,
        input  s0,
        input  bus_valid,
        input  owner_cnt
    );

    modport slave (
        input  req,
        output gnt,
        output s1,
        output s0,
        output bus_valid,
        output owner_cnt
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner selection for the 4:1 data-bus mux, with bounded tenure
// and one dead cycle between owners.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no owner; arbitrate whenever any request is present
//   ST_GRANT | source {s1,s0} owns the bus; owner_cnt counts its tenure
//   ST_TURN  | one-cycle turnaround with no owner; then arbitrate or go idle
module bus_arbiter_rr #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    bus_arbiter_rr_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       state;
    logic [3:0]       gnt_q;
    logic [1:0]       sel_q;
    logic [1:0]       last_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;

    // Search starts just after the previous owner, so it ends up lowest priority.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_TURN: begin
                    if (found) begin
                        state   <= ST_GRANT;
                        gnt_q   <= 4'b0001 << win;
                        sel_q   <= win;
                        last_q  <= win;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // Select stays on the old owner through TURN so d never glitches.
                    if (bus.req[sel_q] && (cnt_q < CNT_LAST)) begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end else begin
                        state   <= ST_TURN;
                        gnt_q   <= 4'b0000;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.s1        = sel_q[1];
    assign bus.s0        = sel_q[0];
    assign bus.bus_valid = valid_q;
    assign bus.owner_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: two instances (HOLD_MAX=2 and 8) checked every cycle
// against an ownership-level reference model, plus directed scenarios and random traffic.
module tb_bus_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    bus_arbiter_rr_if #(.CNT_W(4)) if_a ();
    bus_arbiter_rr_if #(.CNT_W(4)) if_b ();

    bus_arbiter_rr #(.HOLD_MAX(2), .CNT_W(4)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    bus_arbiter_rr #(.HOLD_MAX(8), .CNT_W(4)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, for how long, and who owned it last.
    int m_owner [2];
    int m_cnt   [2];
    int m_last  [2];
    int m_sel   [2];

    logic [3:0] rq_s  [2];
    logic       rs_s  [2];
    logic [3:0] obs_g [2];
    int         waitc [2][4];
    bit         starve_en = 1'b0;

    logic [3:0] r_req [2];
    int         need  [2][4];
    int         gap   [2][4];

    function automatic int hold_of(input int d);
        return (d == 0) ? 2 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step(input int d, input logic [3:0] rq, input logic rs);
        if (rs) begin
            m_owner[d] = -1;
            m_cnt[d]   = 0;
            m_last[d]  = 3;
            m_sel[d]   = 0;
        end else if (m_owner[d] >= 0) begin
            if (rq[m_owner[d]] && (m_cnt[d] < hold_of(d) - 1)) begin
                m_cnt[d]++;
            end else begin
                m_owner[d] = -1;
                m_cnt[d]   = 0;
            end
        end else if (rq != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                int w;
                w = (m_last[d] + k) % 4;
                if (rq[w]) begin
                    m_owner[d] = w;
                    m_sel[d]   = w;
                    m_last[d]  = w;
                    m_cnt[d]   = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic compare_dut(input int d);
        logic [3:0] g;
        logic       v;
        logic [1:0] s;
        logic [3:0] c;
        logic [1:0] gi;
        string      nm;
        if (d == 0) begin
            g = if_a.gnt; v = if_a.bus_valid; s = {if_a.s1, if_a.s0}; c = if_a.owner_cnt; nm = "a";
        end else begin
            g = if_b.gnt; v = if_b.bus_valid; s = {if_b.s1, if_b.s0}; c = if_b.owner_cnt; nm = "b";
        end
        gi = 2'd0;
        for (int k = 0; k < 4; k++) if (g[k]) gi = 2'(k);
        check($sformatf("%s.gnt", nm), 32'(g), (m_owner[d] < 0) ? 32'd0 : (32'd1 << m_owner[d]));
        check($sformatf("%s.bus_valid", nm), 32'(v), (m_owner[d] >= 0) ? 32'd1 : 32'd0);
        check($sformatf("%s.sel", nm), 32'(s), 32'(m_sel[d]));
        check($sformatf("%s.owner_cnt", nm), 32'(c), 32'(m_cnt[d]));
        check($sformatf("%s.onehot0", nm), 32'($onehot0(g)), 32'd1);
        check($sformatf("%s.valid_eq_or", nm), 32'(v), 32'(|g));
        if (v) check($sformatf("%s.sel_eq_gnt", nm), 32'(s), 32'(gi));
        check($sformatf("%s.cnt_max", nm), 32'(int'(c) <= hold_of(d) - 1), 32'd1);
        obs_g[d] = g;
    endtask

    task automatic cycle();
        @(posedge clk);
        rq_s[0] = if_a.req; rs_s[0] = rst_a;
        rq_s[1] = if_b.req; rs_s[1] = rst_b;
        model_step(0, rq_s[0], rs_s[0]);
        model_step(1, rq_s[1], rs_s[1]);
        #1;
        compare_dut(0);
        compare_dut(1);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (obs_g[d][k]) begin
                    if (starve_en && waitc[d][k] > 0)
                        check($sformatf("wait.%0d.%0d", d, k),
                              32'(waitc[d][k] <= 3 * (hold_of(d) + 1) + 1), 32'd1);
                    waitc[d][k] = 0;
                end else if (rq_s[d][k] && !rs_s[d]) begin
                    waitc[d][k]++;
                end else begin
                    waitc[d][k] = 0;
                end
            end
        end
    endtask

    function automatic void update_req(input int d);
        for (int k = 0; k < 4; k++) begin
            if (r_req[d][k]) begin
                if (m_owner[d] == k) begin
                    need[d][k]--;
                    if (need[d][k] <= 0) begin
                        r_req[d][k] = 1'b0;
                        gap[d][k]   = int'($urandom_range(0, 4));
                    end
                end
            end else if (gap[d][k] > 0) begin
                gap[d][k]--;
            end else if ($urandom_range(0, 2) == 0) begin
                r_req[d][k] = 1'b1;
                need[d][k]  = int'($urandom_range(1, 10));
            end
        end
    endfunction

    logic [3:0] rr_exp [13];
    logic [3:0] i_bus;
    int         phase;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_cnt[d] = 0; m_last[d] = 3; m_sel[d] = 0;
            r_req[d] = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                waitc[d][k] = 0; need[d][k] = 0; gap[d][k] = 0;
            end
        end
        rr_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                   4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        i_bus  = 4'b0101;

        // Reset, then no requests
        rst_a = 1'b1; rst_b = 1'b1; if_a.req = 4'b0000; if_b.req = 4'b0000;
        cycle();
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (5) begin
            cycle();
            check("idle.gnt", 32'(if_b.gnt), 32'd0);
            check("idle.valid", 32'(if_b.bus_valid), 32'd0);
            check("idle.sel", 32'({if_b.s1, if_b.s0}), 32'd0);
            check("idle.cnt", 32'(if_b.owner_cnt), 32'd0);
        end

        // Single requester, source 2
        if_b.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("single.gnt", 32'(if_b.gnt), 32'b0100);
            check("single.sel", 32'({if_b.s1, if_b.s0}), 32'd2);
            check("single.cnt", 32'(if_b.owner_cnt), 32'(i));
            check("single.d", 32'(i_bus[{if_b.s1, if_b.s0}]), 32'd1);
        end
        if_b.req = 4'b0000;
        cycle();
        check("single.turn_gnt", 32'(if_b.gnt), 32'd0);
        check("single.turn_sel", 32'({if_b.s1, if_b.s0}), 32'd2);
        cycle();
        check("single.idle_gnt", 32'(if_b.gnt), 32'd0);

        // Round robin, all four requesting, HOLD_MAX=2
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0; if_a.req = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            cycle();
            check($sformatf("rr.gnt%0d", i), 32'(if_a.gnt), 32'(rr_exp[i]));
            if (rr_exp[i] != 4'b0000)
                check($sformatf("rr.sel%0d", i), 32'({if_a.s1, if_a.s0}), 32'((i / 3) % 4));
        end
        if_a.req = 4'b0000;
        cycle(); cycle();

        // Hold limit, HOLD_MAX=8
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0; if_b.req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            cycle();
            phase = i % 9;
            check($sformatf("hold.gnt%0d", i), 32'(if_b.gnt), (phase < 8) ? 32'd1 : 32'd0);
            if (phase < 8) check($sformatf("hold.cnt%0d", i), 32'(if_b.owner_cnt), 32'(phase));
        end
        if_b.req = 4'b0000;
        cycle(); cycle();

        // Reset mid-tenure
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0; if_b.req = 4'b1000;
        repeat (5) cycle();
        check("midrst.pre_gnt", 32'(if_b.gnt), 32'b1000);
        check("midrst.pre_cnt", 32'(if_b.owner_cnt), 32'd4);
        rst_b = 1'b1;
        cycle();
        check("midrst.gnt", 32'(if_b.gnt), 32'd0);
        check("midrst.valid", 32'(if_b.bus_valid), 32'd0);
        check("midrst.sel", 32'({if_b.s1, if_b.s0}), 32'd0);
        check("midrst.cnt", 32'(if_b.owner_cnt), 32'd0);
        rst_b = 1'b0;
        cycle();
        check("midrst.regrant", 32'(if_b.gnt), 32'b1000);
        if_b.req = 4'b0000;
        cycle(); cycle();

        // Non-preemption
        rst_b = 1'b1;
        cycle();
        rst_b = 1'b0; if_b.req = 4'b0100;
        cycle();
        check("nopre.first", 32'(if_b.gnt), 32'b0100);
        if_b.req = 4'b0101;
        repeat (3) begin
            cycle();
            check("nopre.hold", 32'(if_b.gnt), 32'b0100);
        end
        if_b.req = 4'b0001;
        cycle();
        check("nopre.turn", 32'(if_b.gnt), 32'd0);
        cycle();
        check("nopre.next", 32'(if_b.gnt), 32'b0001);
        if_b.req = 4'b0000;
        cycle(); cycle();

        // Random traffic on both instances, starvation bound tracked
        rst_a = 1'b1; rst_b = 1'b1;
        cycle();
        rst_a = 1'b0; rst_b = 1'b0;
        starve_en = 1'b1;
        repeat (3000) begin
            if_a.req = r_req[0];
            if_b.req = r_req[1];
            cycle();
            update_req(0);
            update_req(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter and sequencer for the 4-source computer data bus (4:1 mux, select s1/s0, sources i0..i3, output d).
- Takes per-source requests, grants the bus to one source at a time and drives s1/s0 so the mux routes the granted source to d.
- Bounds bus tenure with a hold limit and inserts one dead (turnaround) cycle between owners.
- Sits between the requesting blocks (e.g. sprinkler valve controller sensors/timers) and the mux select lines.

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one source may own the bus; legal 1..(2^CNT_W)-1
- CNT_W, 4, width of the tenure counter

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  req[k] high = source ik wants the bus; level, held while wanted
- gnt  output 4  one-hot grant; gnt[k] high = source ik owns the bus this cycle; all-zero when no owner
- s1   output 1  mux select MSB (owner index bit 1)
- s0   output 1  mux select LSB (owner index bit 0)
- bus_valid  output 1  high exactly when gnt is non-zero; d is meaningful
- owner_cnt  output CNT_W  cycles the current owner has held the bus, 0-based

Behaviour:
- All outputs registered. Three states: IDLE, GRANT, TURN.
- Reset: the synchronous rst is sampled at the clock edge. On the edge where it is high:
  - state=IDLE, gnt=0000, bus_valid=0, owner_cnt=0, {s1,s0}=00
  - priority pointer last=3, so source 0 has highest priority first.
- rst overrides everything, including mid-tenure. The grant drops on the next edge; there is no TURN cycle after reset.
- Arbitration function, used in IDLE and TURN:
  - Search req starting at index (last+1) mod 4, ascending with wrap.
  - The first set bit wins.
- IDLE:
  - req==0: stay in IDLE; outputs hold (s1/s0 keep the last owner index).
  - req!=0: winner w. Next edge: state=GRANT, gnt=onehot(w), {s1,s0}=w, bus_valid=1, owner_cnt=0, last=w.
  - Latency from req rise to gnt is one clock.
- GRANT, owner w:
  - If req[w]==1 and owner_cnt < HOLD_MAX-1: stay in GRANT, owner_cnt+=1.
  - If req[w]==0, or owner_cnt == HOLD_MAX-1: next edge state=TURN, gnt=0000, bus_valid=0, owner_cnt=0.
  - {s1,s0} stays at w through TURN. The select never changes while a grant is active.
  - Requests from other sources during GRANT are ignored; no preemption.
  - An owner therefore holds the bus for at most HOLD_MAX cycles.
- TURN: always exactly one cycle. Next edge:
  - If req!=0: arbitrate, then move to GRANT as from IDLE. The preempted owner may win again only if no other source requests, because its priority is now lowest.
  - Otherwise: go to IDLE.
- HOLD_MAX=1 is legal: each grant lasts 1 cycle, followed by TURN. Maximum bus utilisation is then 50%.
- Invariants checked by the bench:
  - gnt is one-hot or zero.
  - bus_valid == |gnt.
  - When bus_valid=1, {s1,s0} equals the index of the set gnt bit.
  - owner_cnt <= HOLD_MAX-1.
- Every granted requester is served within 3*(HOLD_MAX+1) cycles of its grant being released (starvation-free).
- Simultaneous req rise on all four sources out of reset: grant order is 0,1,2,3,0,...

Test Plan:
- Reset, then req=0000 for 5 cycles -> gnt=0000, bus_valid=0, {s1,s0}=00, owner_cnt=0 every cycle.
- Single requester: req=0100 held 3 cycles, then 0000 (HOLD_MAX=8):
  - gnt=0100 and {s1,s0}=10 starting one cycle after req rises; owner_cnt counts 0,1,2.
  - One TURN cycle with gnt=0000, then IDLE.
  - With i0..i3=1,0,1,0, mux d=1 while granted.
- Round robin: req=1111 held, HOLD_MAX=2:
  - Grants 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001...
  - {s1,s0} steps 00,01,10,11.
- Hold limit: req=0001 held 20 cycles, HOLD_MAX=8 -> pattern of 8 cycles granted, 1 cycle TURN, repeated. owner_cnt never exceeds 7.
- Reset mid-tenure: grant to source 3 at owner_cnt=4, rst=1 for one edge:
  - Next cycle gnt=0000, bus_valid=0, {s1,s0}=00, owner_cnt=0.
  - With req=1000 still high after rst drops, gnt=1000 returns one cycle later.
- Non-preemption: source 2 owns the bus, then req[0] rises -> gnt stays 0100 until req[2] drops. After one TURN cycle, gnt=0001.
